ahb_bridge_arbiter: RTL and testbench
=====================================

# ahb_bridge_arbiter

Two-master AHB arbiter placed in front of `Bridge_Top`, sharing the single AHB-to-APB bridge (APB slaves at 0x8000_0000, 0x8400_0000 and 0x8800_0000, 64 MB each) between master 0 and master 1. It issues registered grants and tracks address-phase and data-phase ownership separately. It muxes the owner's address, control and write data into the bridge, and broadcasts the bridge's ready, response and read data back to both masters. The block does no address decode; `Bridge_Top` decodes `Pselx`.

## Interface
Parameters:
- `MAX_BURST`, default 16: beats an owner may complete while the other master is requesting before grant is forcibly moved. Legal range 2..255.

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `m0_Hbusreq`, `m1_Hbusreq`  in  1 each  bus request
- `m0_Haddr`, `m1_Haddr`  in  32 each  master address
- `m0_Htrans`, `m1_Htrans`  in  2 each  master transfer type
- `m0_Hwrite`, `m1_Hwrite`  in  1 each  master direction
- `m0_Hwdata`, `m1_Hwdata`  in  32 each  master write data
- `m0_Hgrant`, `m1_Hgrant`  out  1 each  registered grant, exactly one high
- `Hready_m`  out  1  `Hreadyout` broadcast to both masters
- `Hresp_m`  out  2  `Hresp` broadcast
- `Hrdata_m`  out  32  `Hrdata` broadcast
- `Haddr`, `Htrans`, `Hwrite`, `Hwdata`, `Hreadyin`  out  32/2/1/32/1  to bridge
- `Hreadyout`, `Hresp`, `Hrdata`  in  1/2/32  from bridge

## Operation
- State: `grant` (1 bit), `addr_own` (1 bit), `data_own` (1 bit), `last_win` (1 bit), `beat_cnt` (8 bits, saturating at `MAX_BURST`).
- Reset values: `grant`=0, `addr_own`=0, `data_own`=0, `last_win`=1, `beat_cnt`=0.
- Reset outputs: `m0_Hgrant`=1, `m1_Hgrant`=0. Bridge-side `Htrans` is IDLE (2'b00) while `rst` is low.
- Arbitration is evaluated only in cycles where `Hreadyout`=1. With `Hreadyout`=0, all state holds.
- Switch condition (Hreadyout=1, the other master has `Hbusreq`=1, and either):
  - the owner's `Hbusreq`=0, or
  - `beat_cnt`==`MAX_BURST`.
- On a switch: `grant` <= other master, `last_win` <= other master, `beat_cnt` <= 0.
- Neither master requesting: grant parks on the current holder.
- Both masters requesting while the holder has dropped its request: the master ≠ `last_win` wins (round-robin).
- Ownership pipeline, each step on a cycle with `Hreadyout`=1:
  - `addr_own` <= `grant`
  - `data_own` <= `addr_own`
- `beat_cnt` increments when `Hreadyout`=1 and the owner's `Htrans[1]`=1 (NONSEQ or SEQ), saturating at `MAX_BURST`.
- Bridge muxing:
  - `Haddr`, `Htrans`, `Hwrite` come from the `addr_own` master.
  - `Hwdata` comes from the `data_own` master.
  - `Hreadyin` = `Hreadyout` (combinational, single slave).
- `Hresp` is passed through unchanged. ERROR does not affect arbitration.
- Forced handover mid-burst is early burst termination. The displaced master must restart with NONSEQ; the arbiter does not alter `Htrans`.

## Timing
- Request to grant: 1 cycle (registered), given `Hreadyout`=1.
- Grant to address ownership: the next `Hreadyout`=1 edge.
- Minimum request-to-first-address-phase: 2 cycles.
- Data ownership lags address ownership by exactly one accepted transfer, so the last write data of the outgoing master reaches `Hwdata` after handover.
- `Hreadyout` low (bridge wait states) freezes grant, ownership and counter.
- A grant decided during a stall waits until `Hreadyout` returns high.
- Reset asserted mid-transfer: all state returns to reset values immediately. `Htrans`=IDLE while `rst` is low.

## Structure
- Package `ahb_arb_pkg`:
  - `htrans_t` enum: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11
  - `hresp_t`: OKAY=2'b00, ERROR=2'b01
  - `mst_id_t` (1-bit master index)
- Single module; no sub-module. The round-robin pick and the beat counter are small enough to live inline.

## Test plan
- Reset: `rst` low, then high with no requests -> `m0_Hgrant`=1, `Htrans`=IDLE; `Hwdata` follows `m0_Hwdata`.
- m1 alone requests, issues NONSEQ write, Haddr=0x8400_0010, Hwdata=0xA5A5_0001 -> `m1_Hgrant` high 1 cycle after request; bridge sees the address 2 cycles after request and the data the following cycle.
- Both request continuously, `MAX_BURST`=4, m0 holds and streams SEQ beats -> grant moves to m1 on the edge after m0's 4th accepted beat; `beat_cnt` resets to 0.
- m0 drops its request while both were requesting and `last_win`=0 -> m1 granted next cycle. Repeated drop/re-request alternates winners.
- Bridge holds `Hreadyout`=0 for 3 cycles during m0 write 0x8800_0000 while m1 requests -> no grant change until `Hreadyout`=1; `Hwdata` stays m0's data.
- `Hresp`=ERROR, `Hrdata`=0xDEAD_BEEF from bridge -> identical values appear on `Hresp_m` and `Hrdata_m` the same cycle; grant unchanged.

Source files
------------

// File: rtl/ahb_bridge_arbiter_pkg.sv
// Shared types for the two-master AHB arbiter in front of the APB bridge.
// Transfer/response encodings and master index helpers.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01
  } hresp_t;

  typedef logic mst_id_t;

  localparam mst_id_t M0 = 1'b0;
  localparam mst_id_t M1 = 1'b1;

  function automatic logic is_active(
    input logic [1:0] trans
  );
    return trans[1];
  endfunction

  function automatic mst_id_t other(
    input mst_id_t id
  );
    return ~id;
  endfunction

endpackage

// File: rtl/ahb_bridge_arbiter_if.sv
// Per-master AHB request bundle as seen by the bridge arbiter.
// master drives requests, slave (arbiter side) returns the grant.
interface ahb_bridge_arbiter_if;

  logic        Hbusreq;
  logic [31:0] Haddr;
  logic [1:0]  Htrans;
  logic        Hwrite;
  logic [31:0] Hwdata;
  logic        Hgrant;

  modport master (
    output Hbusreq,
    output Haddr,
    output Htrans,
    output Hwrite,
    output Hwdata,
    input  Hgrant
  );

  modport slave (
    input  Hbusreq,
    input  Haddr,
    input  Htrans,
    input  Hwrite,
    input  Hwdata,
    output Hgrant
  );

endinterface

// File: rtl/ahb_bridge_arbiter.sv
// Two-master AHB arbiter sharing one AHB-to-APB bridge.
// Registered grant, separate address/data ownership, beat-limited bursts.
module ahb_bridge_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_Hbusreq,
  input  logic [31:0] m0_Haddr,
  input  logic [1:0]  m0_Htrans,
  input  logic        m0_Hwrite,
  input  logic [31:0] m0_Hwdata,
  output logic        m0_Hgrant,

  input  logic        m1_Hbusreq,
  input  logic [31:0] m1_Haddr,
  input  logic [1:0]  m1_Htrans,
  input  logic        m1_Hwrite,
  input  logic [31:0] m1_Hwdata,
  output logic        m1_Hgrant,

  output logic        Hready_m,
  output logic [1:0]  Hresp_m,
  output logic [31:0] Hrdata_m,

  output logic [31:0] Haddr,
  output logic [1:0]  Htrans,
  output logic        Hwrite,
  output logic [31:0] Hwdata,
  output logic        Hreadyin,

  input  logic        Hreadyout,
  input  logic [1:0]  Hresp,
  input  logic [31:0] Hrdata
);

  localparam logic [7:0] CNT_MAX = 8'(MAX_BURST);

  mst_id_t    grant_q, grant_d;
  mst_id_t    addr_own_q, addr_own_d;
  mst_id_t    data_own_q, data_own_d;
  mst_id_t    last_win_q, last_win_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;

  logic       own_req;
  logic       oth_req;
  logic [1:0] own_trans;
  logic       burst_full;
  logic       switch_en;

  always_comb begin
    own_req    = (grant_q == M1) ? m1_Hbusreq : m0_Hbusreq;
    oth_req    = (grant_q == M1) ? m0_Hbusreq : m1_Hbusreq;
    own_trans  = (grant_q == M1) ? m1_Htrans  : m0_Htrans;
    burst_full = (beat_cnt_q == CNT_MAX);
    // With two masters the round-robin winner is always the non-holder.
    switch_en  = Hreadyout && oth_req
                 && (!own_req || burst_full);
  end

  always_comb begin
    grant_d    = grant_q;
    addr_own_d = addr_own_q;
    data_own_d = data_own_q;
    last_win_d = last_win_q;
    beat_cnt_d = beat_cnt_q;

    if (Hreadyout) begin
      addr_own_d = grant_q;
      data_own_d = addr_own_q;
    end

    if (switch_en) begin
      grant_d    = other(grant_q);
      last_win_d = other(grant_q);
      beat_cnt_d = '0;
    end else if (Hreadyout && is_active(own_trans)
                 && !burst_full) begin
      beat_cnt_d = beat_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q    <= M0;
      addr_own_q <= M0;
      data_own_q <= M0;
      last_win_q <= M1;
      beat_cnt_q <= '0;
    end else begin
      grant_q    <= grant_d;
      addr_own_q <= addr_own_d;
      data_own_q <= data_own_d;
      last_win_q <= last_win_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    m0_Hgrant = (grant_q == M0);
    m1_Hgrant = (grant_q == M1);

    Haddr  = m0_Haddr;
    Htrans = m0_Htrans;
    Hwrite = m0_Hwrite;
    unique case (1'b1)
      (addr_own_q == M1): begin
        Haddr  = m1_Haddr;
        Htrans = m1_Htrans;
        Hwrite = m1_Hwrite;
      end
      default: ;
    endcase
    // Reset is asynchronous, so the bus must be idled combinationally.
    if (!rst) Htrans = IDLE;

    Hwdata = (data_own_q == M1) ? m1_Hwdata : m0_Hwdata;

    Hreadyin = Hreadyout;
    Hready_m = Hreadyout;
    Hresp_m  = Hresp;
    Hrdata_m = Hrdata;
  end

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Directed bench for ahb_bridge_arbiter with MAX_BURST=4.
// Vectors are driven just after each rising edge and checked before the next.
module tb_ahb_bridge_arbiter;
  import ahb_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic        Hready_m;
  logic [1:0]  Hresp_m;
  logic [31:0] Hrdata_m;
  logic [31:0] Haddr;
  logic [1:0]  Htrans;
  logic        Hwrite;
  logic [31:0] Hwdata;
  logic        Hreadyin;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;

  int n_chk;
  int n_pass;

  ahb_bridge_arbiter_if m0 ();
  ahb_bridge_arbiter_if m1 ();

  ahb_bridge_arbiter #(.MAX_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_Hbusreq (m0.Hbusreq),
    .m0_Haddr   (m0.Haddr),
    .m0_Htrans  (m0.Htrans),
    .m0_Hwrite  (m0.Hwrite),
    .m0_Hwdata  (m0.Hwdata),
    .m0_Hgrant  (m0.Hgrant),
    .m1_Hbusreq (m1.Hbusreq),
    .m1_Haddr   (m1.Haddr),
    .m1_Htrans  (m1.Htrans),
    .m1_Hwrite  (m1.Hwrite),
    .m1_Hwdata  (m1.Hwdata),
    .m1_Hgrant  (m1.Hgrant),
    .Hready_m   (Hready_m),
    .Hresp_m    (Hresp_m),
    .Hrdata_m   (Hrdata_m),
    .Haddr      (Haddr),
    .Htrans     (Htrans),
    .Hwrite     (Hwrite),
    .Hwdata     (Hwdata),
    .Hreadyin   (Hreadyin),
    .Hreadyout  (Hreadyout),
    .Hresp      (Hresp),
    .Hrdata     (Hrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h",
                  tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;

    rst        = 1'b0;
    Hreadyout  = 1'b1;
    Hresp      = OKAY;
    Hrdata     = '0;
    m0.Hbusreq = 1'b0;
    m0.Haddr   = 32'h8000_0000;
    m0.Htrans  = NONSEQ;
    m0.Hwrite  = 1'b0;
    m0.Hwdata  = 32'h1111_0000;
    m1.Hbusreq = 1'b0;
    m1.Haddr   = 32'h8400_0000;
    m1.Htrans  = IDLE;
    m1.Hwrite  = 1'b0;
    m1.Hwdata  = 32'h2222_0000;

    // reset
    #2;
    chk("rst_htrans", 32'(Htrans), 32'(IDLE));
    chk("rst_g0", 32'(m0.Hgrant), 32'd1);
    chk("rst_g1", 32'(m1.Hgrant), 32'd0);
    step();
    m0.Htrans = IDLE;
    rst = 1'b1;
    step();
    step();
    chk("idle_g0", 32'(m0.Hgrant), 32'd1);
    chk("idle_htrans", 32'(Htrans), 32'(IDLE));
    chk("idle_wdata", Hwdata, 32'h1111_0000);

    // m1 alone: grant, address, then data
    m1.Hbusreq = 1'b1;
    step();
    chk("m1_grant", 32'(m1.Hgrant), 32'd1);
    chk("m1_g0low", 32'(m0.Hgrant), 32'd0);
    m1.Haddr  = 32'h8400_0010;
    m1.Htrans = NONSEQ;
    m1.Hwrite = 1'b1;
    step();
    chk("m1_haddr", Haddr, 32'h8400_0010);
    chk("m1_htrans", 32'(Htrans), 32'(NONSEQ));
    chk("m1_hwrite", 32'(Hwrite), 32'd1);
    chk("m1_wd_lag", Hwdata, 32'h1111_0000);
    m1.Htrans = IDLE;
    m1.Hwdata = 32'hA5A5_0001;
    step();
    chk("m1_hwdata", Hwdata, 32'hA5A5_0001);

    // hand back to m0
    m1.Hbusreq = 1'b0;
    m0.Hbusreq = 1'b1;
    step();
    chk("back_g0", 32'(m0.Hgrant), 32'd1);

    // both request, m0 bursts 4 beats then loses grant
    m1.Hbusreq = 1'b1;
    m0.Htrans  = NONSEQ;
    for (int i = 1; i <= 4; i++) begin
      step();
      m0.Htrans = SEQ;
      chk($sformatf("burst_hold%0d", i),
          32'(m0.Hgrant), 32'd1);
    end
    step();
    chk("burst_sw_g1", 32'(m1.Hgrant), 32'd1);
    chk("burst_sw_g0", 32'(m0.Hgrant), 32'd0);
    m0.Htrans = IDLE;

    // round-robin on dropped requests
    m1.Hbusreq = 1'b0;
    step();
    chk("rr_a_g0", 32'(m0.Hgrant), 32'd1);
    m1.Hbusreq = 1'b1;
    step();
    chk("rr_b_g0", 32'(m0.Hgrant), 32'd1);
    m0.Hbusreq = 1'b0;
    step();
    chk("rr_c_g1", 32'(m1.Hgrant), 32'd1);
    m0.Hbusreq = 1'b1;
    step();
    chk("rr_d_g1", 32'(m1.Hgrant), 32'd1);
    m1.Hbusreq = 1'b0;
    step();
    chk("rr_e_g0", 32'(m0.Hgrant), 32'd1);

    // wait states during an m0 write
    m0.Haddr  = 32'h8800_0000;
    m0.Htrans = NONSEQ;
    m0.Hwrite = 1'b1;
    step();
    chk("st_haddr", Haddr, 32'h8800_0000);
    m0.Htrans  = IDLE;
    m0.Hwdata  = 32'hC0DE_0088;
    step();
    m0.Hbusreq = 1'b0;
    m1.Hbusreq = 1'b1;
    Hreadyout  = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("st_rdyin%0d", i),
          32'(Hreadyin), 32'd0);
      step();
      chk($sformatf("st_g0_%0d", i),
          32'(m0.Hgrant), 32'd1);
      chk($sformatf("st_wd%0d", i),
          Hwdata, 32'hC0DE_0088);
    end
    Hreadyout = 1'b1;
    step();
    chk("st_rel_g1", 32'(m1.Hgrant), 32'd1);

    // error response broadcast
    Hresp  = ERROR;
    Hrdata = 32'hDEAD_BEEF;
    #1;
    chk("err_resp", 32'(Hresp_m), 32'(ERROR));
    chk("err_rdata", Hrdata_m, 32'hDEAD_BEEF);
    chk("err_ready", 32'(Hready_m), 32'd1);
    step();
    step();
    chk("err_g1", 32'(m1.Hgrant), 32'd1);
    Hresp = OKAY;

    // reset in the middle of an m1 transfer
    m1.Htrans = NONSEQ;
    #1;
    chk("mid_pre", 32'(Htrans), 32'(NONSEQ));
    rst = 1'b0;
    #1;
    chk("mid_htrans", 32'(Htrans), 32'(IDLE));
    chk("mid_g0", 32'(m0.Hgrant), 32'd1);
    chk("mid_g1", 32'(m1.Hgrant), 32'd0);
    chk("mid_haddr", Haddr, 32'h8800_0000);
    chk("mid_wdata", Hwdata, 32'hC0DE_0088);
    step();
    rst = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
